hero_mover: RTL
===============

HERO_MOVER -- requirements
Module: hero_mover

Interface
REQ-001 Parameter STEP_COUNT, default 8: pixels moved per accepted command (1..255).
REQ-002 Parameter X_MAX, default 159: largest legal x coordinate.
REQ-003 Parameter Y_MAX, default 119: largest legal y coordinate.
REQ-004 Parameter X_INIT, default 80: x position after reset.
REQ-005 Parameter Y_INIT, default 60: y position after reset.
REQ-006 clock  input  1  single system clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 tick  input  1  one-cycle step enable from the slow-clock divider.
REQ-009 go  input  1  move request from the upstream move controller, level or pulse.
REQ-010 direct  input  3  direction code: 1 up, 2 down, 3 left, 4 right; 0 and 5..7 are null.
REQ-011 abort  input  1  cancels the move in progress.
REQ-012 xout  output  8  current x coordinate.
REQ-013 yout  output  7  current y coordinate.
REQ-014 plot  output  1  one-cycle pulse; xout/yout hold a new position that cycle.
REQ-015 busy  output  1  high while a command is in progress (states STEP and DONE).
REQ-016 finishmove  output  1  one-cycle pulse when a command completes, aborts or is rejected.
REQ-017 blocked  output  1  sticky per command; set when any step was clamped at a wall.

Function
REQ-018 FSM states: IDLE, STEP, DONE; encodings fixed in the shared package.
REQ-019 IDLE with go=1 and legal direct: latch direct, load step counter with STEP_COUNT, clear blocked, go to STEP next cycle.
REQ-020 IDLE with go=1 and null direct: go to DONE without moving; blocked stays 0.
REQ-021 go while busy is ignored; direct changes during STEP are ignored (latched copy used).
REQ-022 STEP with tick=1 and abort=0: move one pixel in latched direction; decrement counter.
REQ-023 Updated xout/yout and plot=1 appear in the cycle after the tick edge.
REQ-024 Up decrements y, down increments y, left decrements x, right increments x.
REQ-025 Clamp: x saturates in 0..X_MAX and y in 0..Y_MAX; a clamped step still decrements the counter, sets blocked and produces no plot pulse.
REQ-026 STEP transitions to DONE on the edge where the counter decrements from 1 to 0.
REQ-027 abort=1 in STEP has priority over tick: no move that cycle; go to DONE next cycle.
REQ-028 DONE lasts exactly one cycle with finishmove=1, then returns to IDLE.
REQ-029 A new command may be accepted in the IDLE cycle after DONE, giving 1 dead cycle between commands.
REQ-030 Arithmetic: internal coordinate math one bit wider than the port, to detect wrap before clamping; no modular wrap-around visible at the outputs.
REQ-031 blocked holds its value through IDLE until the next command is accepted.

Reset
REQ-032 Asserting reset at any time, including mid-STEP, forces IDLE, xout=X_INIT, yout=Y_INIT, counter=0, plot=0, busy=0, finishmove=0, blocked=0, latched direct=0.
REQ-033 After reset deasserts, the first rising clock edge may accept a command.

Structure
REQ-034 A shared package holds the state encodings, the direction codes (NONE, UP, DOWN, LEFT, RIGHT) and the screen bounds 159/119.
REQ-035 A single sub-module, hero_step_clamp, computes the combinational next coordinate and clamp flag from the position and direction; the FSM, counter and registers stay in hero_mover.

Verification
REQ-036 Reset, then go=1 with direct=4, STEP_COUNT=8, tick every 4 cycles -> 8 plot pulses, x 81..88, y=60, one finishmove, blocked=0.
REQ-037 Start at x=157, direct=4, 8 steps -> x stops at 159 after 2 plots, remaining 6 ticks give no plot, blocked=1, finishmove after the 8th tick.
REQ-038 go=1 with direct=0 -> finishmove 2 cycles later, busy high for 1 cycle, no plot, position unchanged.
REQ-039 direct=1, abort asserted in the same cycle as the 3rd tick -> y=58, no 3rd plot, finishmove next cycle.
REQ-040 Reset asserted after 5 steps of direct=2 -> immediate xout=80, yout=60, busy=0, no finishmove.
REQ-041 go held high with direct changed mid-move -> the latched direction is used, and the next command starts the cycle after finishmove.

Source files
------------

// File: rtl/hero_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hero_pkg
// Description : Shared state encodings, direction codes and screen bounds
//               for the hero sprite mover.
// Revision    : 1.0  initial release
// ============================================================================
package hero_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  localparam int SCREEN_X_MAX = 159;
  localparam int SCREEN_Y_MAX = 119;

  // Codes 0 and 5..7 carry no movement.
  function automatic logic dir_is_legal(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hero_step_clamp.sv
`default_nettype none
// ============================================================================
// Module      : hero_step_clamp
// Description : Next one-pixel position for a direction, saturated to the
//               screen, plus a flag telling whether the step hit a wall.
// Revision    : 1.0  initial release
// ============================================================================
module hero_step_clamp
  import hero_pkg::*;
#(
  parameter int X_MAX = SCREEN_X_MAX,
  parameter int Y_MAX = SCREEN_Y_MAX
) (
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] dir,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic       clamped
);

  localparam logic [8:0] C_X_LIM = 9'(X_MAX);
  localparam logic [7:0] C_Y_LIM = 8'(Y_MAX);

  // One bit of headroom lets underflow show up in the MSB and overflow
  // exceed the limit before anything is truncated to port width.
  logic [8:0] x_wide;
  logic [7:0] y_wide;

  // Compute the unclamped step, then saturate at the screen edges.
  always_comb begin
    x_wide  = {1'b0, x_in};
    y_wide  = {1'b0, y_in};
    x_out   = x_in;
    y_out   = y_in;
    clamped = 1'b0;
    case (dir)
      DIR_UP: begin
        y_wide = {1'b0, y_in} - 8'd1;
        if (y_wide[7]) clamped = 1'b1;
        else           y_out   = y_wide[6:0];
      end
      DIR_DOWN: begin
        y_wide = {1'b0, y_in} + 8'd1;
        if (y_wide > C_Y_LIM) begin
          clamped = 1'b1;
          y_out   = C_Y_LIM[6:0];
        end else begin
          y_out   = y_wide[6:0];
        end
      end
      DIR_LEFT: begin
        x_wide = {1'b0, x_in} - 9'd1;
        if (x_wide[8]) clamped = 1'b1;
        else           x_out   = x_wide[7:0];
      end
      DIR_RIGHT: begin
        x_wide = {1'b0, x_in} + 9'd1;
        if (x_wide > C_X_LIM) begin
          clamped = 1'b1;
          x_out   = C_X_LIM[7:0];
        end else begin
          x_out   = x_wide[7:0];
        end
      end
      default: clamped = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hero_mover.sv
`default_nettype none
// ============================================================================
// Module      : hero_mover
// Description : Moves the hero sprite STEP_COUNT pixels per accepted command,
//               one pixel per tick, saturating at the screen edges.
// Revision    : 1.0  initial release
// ============================================================================
module hero_mover
  import hero_pkg::*;
#(
  parameter int STEP_COUNT = 8,
  parameter int X_MAX      = SCREEN_X_MAX,
  parameter int Y_MAX      = SCREEN_Y_MAX,
  parameter int X_INIT     = 80,
  parameter int Y_INIT     = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       go,
  input  logic [2:0] direct,
  input  logic       abort,
  output logic [7:0] xout,
  output logic [6:0] yout,
  output logic       plot,
  output logic       busy,
  output logic       finishmove,
  output logic       blocked
);

  state_e     state_q, state_d;
  logic [2:0] dir_q, dir_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       plot_q, plot_d;
  logic       blocked_q, blocked_d;

  logic [7:0] step_x;
  logic [6:0] step_y;
  logic       step_clamped;

  hero_step_clamp #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_step_clamp (
    .x_in    (x_q),
    .y_in    (y_q),
    .dir     (dir_q),
    .x_out   (step_x),
    .y_out   (step_y),
    .clamped (step_clamped)
  );

  // Command sequencing: accept, step on ticks, then one-cycle completion.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    plot_d    = 1'b0;
    blocked_d = blocked_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          blocked_d = 1'b0;
          if (dir_is_legal(direct)) begin
            dir_d   = direct;
            cnt_d   = 8'(STEP_COUNT);
            state_d = ST_STEP;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_STEP: begin
        // Abort wins over a coincident tick: the position is left untouched.
        if (abort) begin
          state_d = ST_DONE;
        end else if (tick) begin
          x_d    = step_x;
          y_d    = step_y;
          plot_d = ~step_clamped;
          cnt_d  = cnt_q - 8'd1;
          if (step_clamped) blocked_d = 1'b1;
          if (cnt_q == 8'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset to the home position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_NONE;
      cnt_q     <= 8'd0;
      x_q       <= 8'(X_INIT);
      y_q       <= 7'(Y_INIT);
      plot_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      plot_q    <= plot_d;
      blocked_q <= blocked_d;
    end
  end

  assign xout       = x_q;
  assign yout       = y_q;
  assign plot       = plot_q;
  assign blocked    = blocked_q;
  assign busy       = (state_q != ST_IDLE);
  assign finishmove = (state_q == ST_DONE);

endmodule
`default_nettype wire
